uart_tx_arbiter: RTL and testbench

- Shares the single transmit port of the uart_fifo (tx_byte/transmit, gated by tx_fifo_full) between 4 byte-stream requesters, e.g. the keyboard echo/cursor path, a game-event reporter and a debug/status dumper.
- Uses round-robin arbitration with per-packet locking, so multi-byte messages are never interleaved on the serial line.
- Sits between the requesters and uart_fifo; its outputs drive uart_fifo tx_byte and transmit directly.

---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of the uart_fifo transmit port among four byte-stream requesters.
// Define UART_TX_ARB_LOCK_TIMEOUT_EN to force-release a lock whose owner goes quiet mid-packet.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  input  logic        tx_fifo_full,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  output logic [1:0]  owner,
  output logic        locked,
  output logic        lock_timeout
);

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  // The port widths are fixed for four requesters and the counter is 16 bits wide.
  if (NUM_REQ != 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 4 and TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   winner, cand;
  logic               found;
  logic               accept;
  logic [BYTE_W-1:0]  owner_byte;

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_d;
`endif

  assign owner_byte = req_data[{owner, 3'b000} +: BYTE_W];

  // First valid requester at or after rr_ptr, modulo 4.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register plus the registered transmit datapath.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner    <= '0;
      rr_ptr_q <= '0;
      locked   <= 1'b0;
      transmit <= 1'b0;
      tx_byte  <= '0;
    end else begin
      state_q  <= state_d;
      owner    <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      locked   <= (state_d == LOCKED);
      transmit <= accept;
      tx_byte  <= accept ? owner_byte : 8'h00;
    end
  end

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idle_cnt_q   <= '0;
      lock_timeout <= 1'b0;
    end else begin
      idle_cnt_q   <= idle_cnt_d;
      lock_timeout <= timeout_d;
    end
  end
`else
  assign lock_timeout = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, release on an accepted last byte (or on a stalled owner).
  always_comb begin
    state_d  = state_q;
    owner_d  = owner;
    rr_ptr_d = rr_ptr_q;
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (found) begin
          state_d = LOCKED;
          owner_d = winner;
        end
      end
      LOCKED: begin
        if (accept) begin
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
          if (req_last[owner]) begin
            state_d  = IDLE;
            rr_ptr_d = owner + IDX_W'(1);
          end
        end
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
        // Only an absent owner counts; a full-FIFO stall with the owner valid does not.
        else if (!req_valid[owner]) begin
          if (idle_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            rr_ptr_d   = owner + IDX_W'(1);
            idle_cnt_d = '0;
            timeout_d  = 1'b1;
          end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept handshake; transmit high blocks back-to-back accepts, giving one byte per two cycles.
  always_comb begin
    accept    = 1'b0;
    req_ready = '0;
    if (state_q == LOCKED && !RESET) begin
      accept = req_valid[owner] & ~tx_fifo_full & ~transmit;
    end
    if (accept) begin
      req_ready = 4'b0001 << owner;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the inputs, a monitor checks every transmit.
module tb_uart_tx_arbiter;

  logic        CLK;
  logic        RESET;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_fifo_full;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic [1:0]  owner;
  logic        locked;
  logic        lock_timeout;

  int checks = 0;
  int errors = 0;
  int g0_cnt = 0;
  int to_cnt = 0;

  typedef logic [8:0] ent_t;        // {last, data}
  typedef ent_t pq_t [$];
  pq_t pq [4];
  logic [9:0] exp_q [$];            // {owner, byte}

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_fifo_full(tx_fifo_full),
    .tx_byte(tx_byte), .transmit(transmit), .owner(owner), .locked(locked),
    .lock_timeout(lock_timeout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Requester driver: pop on an accepted byte, present the queue head 1ns after the edge.
  initial begin
    logic [3:0] snap;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge CLK);
      snap = req_ready;
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (snap[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = pq[i][0][7:0];
          req_last[i]        = pq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: every transmit strobe must match the next expected {owner, byte}.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge CLK);
      if (req_ready[0]) g0_cnt++;
      if (lock_timeout) to_cnt++;
      if (transmit) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx: got owner %0d byte %02h, expected no transmit", owner, tx_byte);
        end else begin
          e = exp_q.pop_front();
          if ({owner, tx_byte} !== e) begin
            errors++;
            $display("FAIL tx_byte: got owner %0d byte %02h, expected owner %0d byte %02h",
                     owner, tx_byte, e[9:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < 4; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending() || locked || transmit) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, %0d bytes outstanding, expected drained",
               name, budget, exp_q.size());
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  initial begin
    logic [5:0] s1 [8];
    RESET = 1'b1;
    tx_fifo_full = 1'b0;
    do_reset();
    RESET = 1'b1;
    step();
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_transmit", 32'(transmit), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'h0);
    RESET = 1'b0;
    step();

    // Single requester: {locked, transmit, req_ready} per cycle after the load.
    s1 = '{6'b0_0_0000, 6'b1_0_0001, 6'b1_1_0000, 6'b1_0_0001,
           6'b1_1_0000, 6'b1_0_0001, 6'b0_1_0000, 6'b0_0_0000};
    pq[0].push_back({1'b0, 8'h57});
    pq[0].push_back({1'b0, 8'h41});
    pq[0].push_back({1'b1, 8'h44});
    exp_q.push_back({2'd0, 8'h57});
    exp_q.push_back({2'd0, 8'h41});
    exp_q.push_back({2'd0, 8'h44});
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("single_cyc%0d", c + 1), 32'({locked, transmit, req_ready}), 32'(s1[c]));
    end
    chk("single_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);
    drain("single_drain", 20);

    // Contention after reset: service order 0, 2, 3 with no interleaving.
    do_reset();
    pq[0].push_back({1'b0, 8'hA0}); pq[0].push_back({1'b1, 8'hA1});
    pq[2].push_back({1'b0, 8'hC0}); pq[2].push_back({1'b1, 8'hC1});
    pq[3].push_back({1'b0, 8'hD0}); pq[3].push_back({1'b1, 8'hD1});
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd0, 8'hA1});
    exp_q.push_back({2'd2, 8'hC0}); exp_q.push_back({2'd2, 8'hC1});
    exp_q.push_back({2'd3, 8'hD0}); exp_q.push_back({2'd3, 8'hD1});
    drain("contention_drain", 60);
    chk("contention_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

    // Backpressure: FIFO full for 10 cycles while req1 holds the lock.
    tx_fifo_full = 1'b1;
    pq[1].push_back({1'b0, 8'h10});
    pq[1].push_back({1'b1, 8'h11});
    exp_q.push_back({2'd1, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("full_cyc%0d", c + 1), 32'({transmit, req_ready}), 32'h0);
    end
    chk("full_locked", 32'({locked, owner}), 32'({1'b1, 2'd1}));
    tx_fifo_full = 1'b0;
    step();
    chk("full_release_tx", 32'(transmit), 32'h1);
    drain("full_drain", 20);

    // Wrap: owner 3 finishes while req0 and req3 both wait; req0 must win.
    pq[3].push_back({1'b0, 8'h30});
    pq[3].push_back({1'b1, 8'h31});
    step();
    step();
    chk("wrap_owner3", 32'({locked, owner}), 32'({1'b1, 2'd3}));
    pq[0].push_back({1'b1, 8'h01});
    pq[3].push_back({1'b1, 8'h32});
    exp_q.push_back({2'd3, 8'h30}); exp_q.push_back({2'd3, 8'h31});
    exp_q.push_back({2'd0, 8'h01}); exp_q.push_back({2'd3, 8'h32});
    drain("wrap_drain", 40);
    chk("wrap_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);

    // Reset mid-packet after the first of three bytes from req2.
    pq[2].push_back({1'b0, 8'h20});
    pq[2].push_back({1'b0, 8'h21});
    pq[2].push_back({1'b1, 8'h22});
    exp_q.push_back({2'd2, 8'h20});
    step(); step(); step();
    chk("midrst_first_tx", 32'({transmit, tx_byte}), 32'({1'b1, 8'h20}));
    RESET = 1'b1;
    step();
    chk("midrst_tx_byte", 32'(tx_byte), 32'h00);
    chk("midrst_transmit", 32'(transmit), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_owner_locked", 32'({owner, locked, lock_timeout}), 32'h0);
    chk("midrst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    RESET = 1'b0;
    pq[2].delete();
    pq[2].push_back({1'b0, 8'h20});
    pq[2].push_back({1'b0, 8'h21});
    pq[2].push_back({1'b1, 8'h22});
    exp_q.push_back({2'd2, 8'h20});
    exp_q.push_back({2'd2, 8'h21});
    exp_q.push_back({2'd2, 8'h22});
    drain("midrst_drain", 30);

    // Owner stalls mid-packet while req0 waits.
    pq[1].push_back({1'b0, 8'h40});
    exp_q.push_back({2'd1, 8'h40});
    step(); step(); step();
    pq[0].push_back({1'b1, 8'h50});
    g0_cnt = 0;
    to_cnt = 0;
    for (int c = 0; c < 20; c++) step();
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    chk("stall_timeout_pulses", 32'(to_cnt), 32'd1);
    chk("stall_req0_grants", 32'(g0_cnt), 32'd1);
    exp_q.push_back({2'd0, 8'h50});
    pq[1].push_back({1'b1, 8'h41});
    exp_q.push_back({2'd1, 8'h41});
`else
    chk("stall_timeout_pulses", 32'(to_cnt), 32'd0);
    chk("stall_req0_grants", 32'(g0_cnt), 32'd0);
    chk("stall_lock_held", 32'({locked, owner}), 32'({1'b1, 2'd1}));
    pq[1].push_back({1'b1, 8'h41});
    exp_q.push_back({2'd1, 8'h41});
    exp_q.push_back({2'd0, 8'h50});
`endif
    drain("stall_drain", 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
